fifo_ctrl: RTL and testbench

Pointer and occupancy controller that sits directly upstream of the dual_port 8x4 memory. It converts push/pop requests into the memory's write enable, write address and read address. It also maintains the occupancy count and the empty/full/almost flags. The memory's combinational read port presents the head entry at addr_rd, so fifo_ctrl plus dual_port together form a synchronous FIFO.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_ptr.sv | 21 ++
 rtl/fifo_ctrl.sv | 115 +++++++++++
 tb/tb_fifo_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing defaults and the occupancy state encoding for the FIFO controller.
package fifo_pkg;
  localparam int DEPTH     = 8;
  localparam int AW        = 3;
  localparam int AF_THRESH = 6;
  localparam int AE_THRESH = 2;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } fifo_state_t;
endpackage

// File: rtl/fifo_ptr.sv
// Purpose: AW-bit wrapping pointer, advances by one when enabled.
// Latency: new value visible the cycle after en.
// Backpressure: none; the caller gates en.
module fifo_ptr #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [AW-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Purpose: pointer/occupancy controller in front of a dual-port memory, forming a sync FIFO.
// Latency: write lands on the push edge; head entry readable the cycle after its write.
// Backpressure: push rejected while full, pop rejected while empty (sticky error flags).
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH     = fifo_pkg::DEPTH,
  parameter int AW        = fifo_pkg::AW,
  parameter int AF_THRESH = fifo_pkg::AF_THRESH,
  parameter int AE_THRESH = fifo_pkg::AE_THRESH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clr_err,
  output logic          we_dual,
  output logic [AW-1:0] addr_wr,
  output logic [AW-1:0] addr_rd,
  output logic [AW:0]   fifo_cnt,
  output logic          empty,
  output logic          full,
  output logic          almost_empty,
  output logic          almost_full,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LVL   = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_LVL   = (AW+1)'(AE_THRESH);

  fifo_state_t state, next_state;
  logic        push_ok, pop_ok;

  assign empty   = (state == EMPTY);
  assign full    = (state == FULL);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign we_dual = push_ok;

  fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (push_ok),
    .ptr   (addr_wr)
  );

  fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pop_ok),
    .ptr   (addr_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_cnt <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      EMPTY: begin
        if (push_ok) next_state = PARTIAL;
      end
      PARTIAL: begin
        if (pop_ok && !push_ok && fifo_cnt == CNT_ONE) begin
          next_state = EMPTY;
        end else if (push_ok && !pop_ok && fifo_cnt == CNT_LAST) begin
          next_state = FULL;
        end
      end
      FULL: begin
        if (pop_ok) next_state = PARTIAL;
      end
      default: next_state = EMPTY;
    endcase
  end

  assign almost_full  = (fifo_cnt >= AF_LVL);
  assign almost_empty = (fifo_cnt <= AE_LVL);

  // A set in the same cycle as clr_err takes priority over the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (push & full)  | (overflow  & ~clr_err);
      underflow <= (pop  & empty) | (underflow & ~clr_err);
    end
  end

  flags_match_count: assert property (@(posedge clk) disable iff (!rst_n)
    (empty == (fifo_cnt == '0)) && (full == (fifo_cnt == CNT_MAX)));

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural 8x4 memory standing in for dual_port.
module tb_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic       push;
  logic       pop;
  logic       clr_err;
  logic       we_dual;
  logic [2:0] addr_wr;
  logic [2:0] addr_rd;
  logic [3:0] fifo_cnt;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic       overflow;
  logic       underflow;

  logic [3:0] din;
  logic [3:0] mem [8];
  logic [3:0] dout_dual;
  logic [3:0] exp_q [$];
  logic [3:0] exp_d;

  int checks = 0;
  int errors = 0;

  fifo_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .pop          (pop),
    .clr_err      (clr_err),
    .we_dual      (we_dual),
    .addr_wr      (addr_wr),
    .addr_rd      (addr_rd),
    .fifo_cnt     (fifo_cnt),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (we_dual) mem[addr_wr] <= din;
  assign dout_dual = mem[addr_rd];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = 4'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", fifo_cnt); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got %b want 1", almost_empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b want 0", almost_full); end
    checks++; if (addr_wr !== 3'd0 || addr_rd !== 3'd0) begin errors++; $display("FAIL reset_ptrs got wr=%0d rd=%0d want 0/0", addr_wr, addr_rd); end
    checks++; if (we_dual !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", we_dual); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_err got ovf=%b unf=%b want 0/0", overflow, underflow); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; din = 4'(i + 1);
      @(negedge clk);
      checks++; if (we_dual !== 1'b1) begin errors++; $display("FAIL fill_we[%0d] got %b want 1", i, we_dual); end
      checks++; if (addr_wr !== 3'(i)) begin errors++; $display("FAIL fill_addr_wr[%0d] got %0d want %0d", i, addr_wr, i); end
      tick();
      checks++; if (fifo_cnt !== 4'(i + 1)) begin errors++; $display("FAIL fill_cnt[%0d] got %0d want %0d", i, fifo_cnt, i + 1); end
      checks++; if (almost_full !== (i + 1 >= 6)) begin errors++; $display("FAIL fill_af[%0d] got %b want %b", i, almost_full, (i + 1 >= 6)); end
      checks++; if (full !== (i == 7)) begin errors++; $display("FAIL fill_full[%0d] got %b want %b", i, full, (i == 7)); end
    end
    idle_inputs();
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1;
      @(negedge clk);
      checks++; if (dout_dual !== 4'(i + 1)) begin errors++; $display("FAIL drain_data[%0d] got %h want %h", i, dout_dual, 4'(i + 1)); end
      checks++; if (addr_rd !== 3'(i)) begin errors++; $display("FAIL drain_addr_rd[%0d] got %0d want %0d", i, addr_rd, i); end
      tick();
      checks++; if (fifo_cnt !== 4'(7 - i)) begin errors++; $display("FAIL drain_cnt[%0d] got %0d want %0d", i, fifo_cnt, 7 - i); end
      checks++; if (almost_empty !== (7 - i <= 2)) begin errors++; $display("FAIL drain_ae[%0d] got %b want %b", i, almost_empty, (7 - i <= 2)); end
    end
    idle_inputs();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", empty); end
    checks++; if (addr_rd !== 3'd0) begin errors++; $display("FAIL drain_wrap got %0d want 0", addr_rd); end
  endtask

  // Pointers start at 0/0 here; three preloads then ten push+pop cycles.
  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; din = 4'(9 + i);
      exp_q.push_back(din);
      tick();
    end
    checks++; if (fifo_cnt !== 4'd3) begin errors++; $display("FAIL b2b_preload_cnt got %0d want 3", fifo_cnt); end
    for (int i = 0; i < 10; i++) begin
      push = 1'b1; pop = 1'b1; din = 4'(12 + i);
      @(negedge clk);
      exp_d = exp_q.pop_front();
      exp_q.push_back(din);
      checks++; if (dout_dual !== exp_d) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, dout_dual, exp_d); end
      tick();
      checks++; if (fifo_cnt !== 4'd3) begin errors++; $display("FAIL b2b_cnt[%0d] got %0d want 3", i, fifo_cnt); end
    end
    idle_inputs();
    checks++; if (addr_wr !== 3'd5 || addr_rd !== 3'd2) begin errors++; $display("FAIL b2b_ptrs got wr=%0d rd=%0d want 5/2", addr_wr, addr_rd); end
    for (int i = 0; i < 3; i++) begin
      pop = 1'b1;
      @(negedge clk);
      exp_d = exp_q.pop_front();
      checks++; if (dout_dual !== exp_d) begin errors++; $display("FAIL b2b_tail[%0d] got %h want %h", i, dout_dual, exp_d); end
      tick();
    end
    idle_inputs();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b want 1", empty); end
  endtask

  // Enters empty with both pointers at 5.
  task automatic test_errors();
    push = 1'b1;
    for (int i = 0; i < 8; i++) begin din = 4'(i); tick(); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL err_full got %b want 1", full); end
    din = 4'hf;
    @(negedge clk);
    checks++; if (we_dual !== 1'b0) begin errors++; $display("FAIL err_ovf_we got %b want 0", we_dual); end
    tick();
    push = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL err_ovf_set got %b want 1", overflow); end
    checks++; if (fifo_cnt !== 4'd8 || addr_wr !== 3'd5) begin errors++; $display("FAIL err_ovf_state got cnt=%0d wr=%0d want 8/5", fifo_cnt, addr_wr); end
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL err_ovf_sticky got %b want 1", overflow); end
    pop = 1'b1;
    repeat (8) tick();
    push = 1'b1; din = 4'h7;
    tick();
    idle_inputs();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL err_unf_set got %b want 1", underflow); end
    checks++; if (fifo_cnt !== 4'd1 || empty !== 1'b0) begin errors++; $display("FAIL err_unf_cnt got cnt=%0d empty=%b want 1/0", fifo_cnt, empty); end
    checks++; if (addr_rd !== 3'd5) begin errors++; $display("FAIL err_unf_rd got %0d want 5", addr_rd); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL err_clr got ovf=%b unf=%b want 0/0", overflow, underflow); end
    push = 1'b1;
    repeat (7) tick();
    clr_err = 1'b1;
    tick();
    idle_inputs();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL err_set_wins got %b want 1", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL err_set_wins_unf got %b want 0", underflow); end
  endtask

  // Enters full; pops to 5 then resets with push held.
  task automatic test_reset_mid();
    pop = 1'b1;
    repeat (3) tick();
    pop = 1'b0;
    checks++; if (fifo_cnt !== 4'd5) begin errors++; $display("FAIL rmid_pre_cnt got %0d want 5", fifo_cnt); end
    rst_n = 1'b0; push = 1'b1; din = 4'ha;
    tick();
    rst_n = 1'b1; push = 1'b0;
    checks++; if (fifo_cnt !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL rmid_cnt got cnt=%0d empty=%b want 0/1", fifo_cnt, empty); end
    checks++; if (addr_wr !== 3'd0 || addr_rd !== 3'd0) begin errors++; $display("FAIL rmid_ptrs got wr=%0d rd=%0d want 0/0", addr_wr, addr_rd); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_ovf got %b want 0", overflow); end
    tick();
    checks++; if (fifo_cnt !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL rmid_hold got cnt=%0d empty=%b want 0/1", fifo_cnt, empty); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
